ahb_arbiter_slave_6: RTL and testbench

AHB_ARBITER_SLAVE_6 -- requirements
Module: AHB_arbiter_slave_6

---
 rtl/ahb_arbiter_slave_6.sv | 106 ++++++++++
 tb/tb_ahb_arbiter_slave_6.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_slave_6.sv
// Round-robin AHB arbiter for slave_6: registered address/data-phase selects, 1-cycle grant latency.
// Backpressure: everything holds while hready=0; locked owners keep the grant until they release.
module ahb_arbiter_slave_6 #(
  parameter int CHANNEL_NUM = 2
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0]      hlock,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      sel_addr,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic [CHANNEL_NUM-1:0]      hgrant,
  output logic                        busy
);

  localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_last;
  logic [CHANNEL_NUM-1:0] r_sel_addr;
  logic [CHANNEL_NUM-1:0] r_sel_data;

  logic                   w_own_req;
  logic                   w_own_lock;
  logic [1:0]             w_own_trans;
  logic                   w_own_data;
  logic                   w_arb;
  logic                   w_found;
  logic [IW-1:0]          w_win;
  logic [IW-1:0]          w_cand;
  logic [CHANNEL_NUM-1:0] w_win_oh;

  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CHANNEL_NUM) s = s - CHANNEL_NUM;
    return s[IW-1:0];
  endfunction

  assign w_own_req   = hreq[r_owner];
  assign w_own_lock  = hlock[r_owner];
  assign w_own_trans = htrans[r_owner];
  assign w_own_data  = (r_state == ST_OWN) && w_own_trans[1];

  // Unlocked NONSEQ/IDLE marks a transfer boundary where another master may take over.
  assign w_arb = (r_state == ST_IDLE) || !w_own_req ||
                 (!w_own_lock && ((w_own_trans == 2'b00) || (w_own_trans == 2'b10)));

  // Search starts just after the last winner, so the current owner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      w_cand = f_wrap(r_last, k);
      if (!w_found && hreq[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_win_oh[i] = (int'(w_win) == i);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_last     <= IW'(CHANNEL_NUM - 1);
      r_sel_addr <= '0;
      r_sel_data <= '0;
    end else if (hready) begin
      r_sel_data <= w_own_data ? r_sel_addr : '0;
      if (w_arb) begin
        if (w_found) begin
          r_state    <= ST_OWN;
          r_owner    <= w_win;
          r_last     <= w_win;
          r_sel_addr <= w_win_oh;
        end else begin
          r_state    <= ST_IDLE;
          r_sel_addr <= '0;
        end
      end
    end
  end

  assign sel_addr = r_sel_addr;
  assign sel_data = r_sel_data;
  assign hgrant   = r_sel_addr;
  assign busy     = (|r_sel_addr) || (|r_sel_data);

endmodule

// File: tb/tb_ahb_arbiter_slave_6.sv
// Bench for ahb_arbiter_slave_6 (3 channels): directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against an integer-level arbitration model.
module tb_ahb_arbiter_slave_6;

  localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic [2:0]      hreq = '0;
  logic [2:0]      hlock = '0;
  logic [2:0][1:0] htrans = '0;
  logic            hready = 1'b0;
  logic [2:0]      sel_addr, sel_data, hgrant;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: -1 means "nobody".
  int m_owner = -1;
  int m_data  = -1;
  int m_last  = 2;

  ahb_arbiter_slave_6 #(.CHANNEL_NUM(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hreq(hreq), .hlock(hlock), .htrans(htrans),
    .hready(hready), .sel_addr(sel_addr), .sel_data(sel_data), .hgrant(hgrant), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [2:0] oh(input int i);
    logic [2:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  winner;
    int  c;
    bit  arb;
    if (HRESET) begin
      m_owner = -1;
      m_data  = -1;
      m_last  = 2;
    end else if (hready) begin
      if (m_owner >= 0)
        arb = !hreq[m_owner] ||
              (!hlock[m_owner] && (htrans[m_owner] == I || htrans[m_owner] == N));
      else
        arb = 1'b1;
      m_data = (m_owner >= 0 && htrans[m_owner][1]) ? m_owner : -1;
      if (arb) begin
        winner = -1;
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (winner < 0 && hreq[c]) winner = c;
        end
        if (winner >= 0) begin
          m_owner = winner;
          m_last  = winner;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("model_sel_addr", sel_addr, oh(m_owner));
    chk("model_sel_data", sel_data, oh(m_data));
    chk("model_hgrant", hgrant, oh(m_owner));
    chk("model_busy", {2'b00, busy}, {2'b00, (m_owner >= 0) || (m_data >= 0)});
  endtask

  task automatic step(input logic rst, input logic [2:0] rq, input logic [2:0] lk,
                      input logic [5:0] tr, input logic rdy);
    HRESET = rst;
    hreq   = rq;
    hlock  = lk;
    htrans = tr;
    hready = rdy;
    @(posedge HCLK);
    model_update();
    @(negedge HCLK);
    compare_model();
  endtask

  initial begin
    // Reset state
    step(1'b1, 3'b000, 3'b000, {I, I, I}, 1'b1);
    chk("reset_sel_addr", sel_addr, 3'b000);
    chk("reset_sel_data", sel_data, 3'b000);
    chk("reset_busy", {2'b00, busy}, 3'b000);

    // First grant from idle
    step(1'b0, 3'b011, 3'b000, {I, I, I}, 1'b1);
    chk("first_grant_sel_addr", sel_addr, 3'b001);
    chk("first_grant_hgrant", hgrant, 3'b001);
    chk("first_grant_busy", {2'b00, busy}, 3'b001);

    // SEQ beat keeps the grant and opens a data phase
    step(1'b0, 3'b011, 3'b000, {I, I, S}, 1'b1);
    chk("seq_hold_addr", sel_addr, 3'b001);
    chk("seq_hold_data", sel_data, 3'b001);

    // Arbitration point stalled by hready=0
    for (int w = 0; w < 3; w++) begin
      step(1'b0, 3'b011, 3'b000, {I, I, N}, 1'b0);
      chk("stall_addr", sel_addr, 3'b001);
      chk("stall_data", sel_data, 3'b001);
    end
    step(1'b0, 3'b011, 3'b000, {I, I, N}, 1'b1);
    chk("switch_after_stall_addr", sel_addr, 3'b010);
    chk("switch_after_stall_data", sel_data, 3'b001);

    // Owner 1 drops request while IDLE -> master 2
    step(1'b0, 3'b100, 3'b000, {I, I, I}, 1'b1);
    chk("handoff_to2_addr", sel_addr, 3'b100);
    chk("handoff_to2_data", sel_data, 3'b000);

    // Sole requester 2 keeps the grant
    step(1'b0, 3'b100, 3'b000, {N, I, I}, 1'b1);
    chk("sole_req2_addr", sel_addr, 3'b100);
    chk("sole_req2_data", sel_data, 3'b100);

    // Wrap from last=2 to master 0
    step(1'b0, 3'b101, 3'b000, {N, I, I}, 1'b1);
    chk("wrap_addr", sel_addr, 3'b001);
    chk("wrap_data", sel_data, 3'b100);

    // Sole requester 0 retains without an idle gap
    step(1'b0, 3'b001, 3'b000, {I, I, N}, 1'b1);
    chk("sole_req0_addr", sel_addr, 3'b001);

    // Locked owner 0 through NONSEQ/SEQ/IDLE
    step(1'b0, 3'b111, 3'b001, {I, I, N}, 1'b1);
    chk("lock_nonseq_addr", sel_addr, 3'b001);
    step(1'b0, 3'b111, 3'b001, {I, I, S}, 1'b1);
    chk("lock_seq_addr", sel_addr, 3'b001);
    step(1'b0, 3'b111, 3'b001, {I, I, I}, 1'b1);
    chk("lock_idle_addr", sel_addr, 3'b001);
    chk("lock_idle_data", sel_data, 3'b000);
    step(1'b0, 3'b111, 3'b000, {I, I, I}, 1'b1);
    chk("unlock_addr", sel_addr, 3'b010);

    // Reset mid-burst
    step(1'b0, 3'b111, 3'b000, {I, S, I}, 1'b1);
    chk("pre_reset_addr", sel_addr, 3'b010);
    chk("pre_reset_data", sel_data, 3'b010);
    step(1'b1, 3'b111, 3'b010, {I, S, I}, 1'b1);
    chk("midburst_reset_addr", sel_addr, 3'b000);
    chk("midburst_reset_data", sel_data, 3'b000);
    chk("midburst_reset_busy", {2'b00, busy}, 3'b000);
    step(1'b0, 3'b110, 3'b000, {I, I, I}, 1'b1);
    chk("post_reset_addr", sel_addr, 3'b010);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       rst, rdy;
      logic [2:0] rq, lk;
      logic [5:0] tr;
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rq  = 3'($urandom_range(0, 7));
      lk  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      tr  = 6'($urandom_range(0, 63));
      step(rst, rq, lk, tr, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
